// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM:
// state encoding, opcodes, mux encodings and the control word layout.
package mc_pkg;

    // Controller states; FETCH must be 0 so a cleared register means FETCH.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    // IR[31:26] opcodes understood by the controller.
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ALU B-operand select.
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    // PC source select.
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU operation request toward the ALU control decoder.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Raw per-state control word before the pc_en combination.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_if.sv
// Bundle between the main controller and the datapath. The controller
// side (master) receives opcode/flags and drives every enable and select.
interface mc_if;
    import mc_pkg::*;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op1;
    logic       alu_op0;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op1, alu_op0,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op1, alu_op0,
               pc_source, illegal_op, state
    );

endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM. The state register is the only
// storage; every output is decoded combinationally from the state plus
// mem_ready and zero, and is forced to 0 while rst_n is low.
module mc_control
    import mc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    mc_if.master bus
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    // State register: synchronous active-low reset back to FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection; mem_ready only matters in the memory states.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:     state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
                    state_next = S_MEM_ADDR;
                end else if (bus.opcode == OP_R) begin
                    state_next = S_R_EXEC;
                end else if (bus.opcode == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (bus.opcode == OP_J) begin
                    state_next = S_JUMP;
                end else if (bus.opcode == OP_ADDI) begin
                    state_next = S_ADDI_EXEC;
                end else begin
                    state_next = S_ILLEGAL;
                end
            end
            // Opcode is held stable from DECODE, so it still picks lw vs sw here.
            S_MEM_ADDR:  state_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ILLEGAL:   state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    // Per-state control word; anything not set stays 0. Reset overrides all.
    always_comb begin
        ctrl = '0;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                // PC and IR only load once the instruction word has arrived.
                ctrl.pc_write  = bus.mem_ready;
                ctrl.ir_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    assign bus.pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & bus.zero);
    assign bus.iord       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op1    = ctrl.alu_op[1];
    assign bus.alu_op0    = ctrl.alu_op[0];
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.illegal_op = ctrl.illegal_op;
    // Debug view reads FETCH while reset is held, even before the first edge.
    assign bus.state      = rst_n ? state_reg : S_FETCH;

endmodule
